// File: rtl/sync_lock_monitor.sv
// sync_lock_monitor: checks each period/duty measurement against a nominal
// window, keeps an exponentially smoothed period, and tracks lock of the
// incoming sync signal with hysteresis plus a watchdog for signal loss.
// Optional build macro SYNC_LOCK_DUTY_CHECK_EN adds a duty-cycle window
// to the in-window decision; without it the duty port is ignored.
module sync_lock_monitor #(
    parameter int WIDTH        = 32,
    parameter int NOM_PERIOD   = 60,
    parameter int TOL          = 4,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int TIMEOUT      = 200,
    parameter int AVG_SHIFT    = 2,
    parameter int DUTY_NOM     = 20,
    parameter int DUTY_TOL     = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        period,
    input  logic [WIDTH-1:0]        duty,
    input  logic                    meas_valid,
    output logic [1:0]              state,
    output logic                    locked,
    output logic                    in_window,
    output logic signed [WIDTH:0]   period_err,
    output logic [WIDTH-1:0]        avg_period,
    output logic                    loss
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int GW = (LOCK_COUNT   > 0) ? $clog2(LOCK_COUNT + 1)   : 1;
    localparam int BW = (UNLOCK_COUNT > 0) ? $clog2(UNLOCK_COUNT + 1) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [GW-1:0] LOCK_C    = GW'(LOCK_COUNT);
    localparam logic [BW-1:0] UNLOCK_C  = BW'(UNLOCK_COUNT);
    localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

    localparam logic signed [WIDTH:0] NOM_S = (WIDTH + 1)'(NOM_PERIOD);
    localparam logic signed [WIDTH:0] TOL_S = (WIDTH + 1)'(TOL);

    state_t                  cstate, nstate;
    logic [GW-1:0]           good_cnt, good_n;
    logic [BW-1:0]           bad_cnt, bad_n;
    logic [WW-1:0]           wd_cnt, wd_n;
    logic                    loss_n;
    logic signed [WIDTH:0]   err_c;
    logic                    in_win_c;

    // Saturating increment of the consecutive-good counter.
    function automatic logic [GW-1:0] sat_inc(input logic [GW-1:0] c);
        return (c == LOCK_C) ? c : c + 1'b1;
    endfunction

    // One step of the exponential average; the difference is carried one bit
    // wider and signed so that a falling period pulls the average down.
    function automatic logic [WIDTH-1:0] avg_step(input logic [WIDTH-1:0] avg,
                                                  input logic [WIDTH-1:0] sample);
        logic signed [WIDTH:0] delta;
        delta = $signed({1'b0, sample}) - $signed({1'b0, avg});
        return avg + WIDTH'(delta >>> AVG_SHIFT);
    endfunction

`ifdef SYNC_LOCK_DUTY_CHECK_EN
    localparam logic signed [WIDTH:0] DUTY_NOM_S = (WIDTH + 1)'(DUTY_NOM);
    localparam logic signed [WIDTH:0] DUTY_TOL_S = (WIDTH + 1)'(DUTY_TOL);
    logic signed [WIDTH:0] duty_err_c;

    // Window decision on the incoming sample: period and duty must both fit.
    always_comb begin
        err_c      = $signed({1'b0, period}) - NOM_S;
        duty_err_c = $signed({1'b0, duty}) - DUTY_NOM_S;
        in_win_c   = (err_c >= -TOL_S) && (err_c <= TOL_S) &&
                     (duty_err_c >= -DUTY_TOL_S) && (duty_err_c <= DUTY_TOL_S);
    end
`else
    // Duty is intentionally ignored in this build; keep it referenced.
    logic unused_duty;
    assign unused_duty = ^{duty, DUTY_NOM[0], DUTY_TOL[0]};

    // Window decision on the incoming sample: period only.
    always_comb begin
        err_c    = $signed({1'b0, period}) - NOM_S;
        in_win_c = (err_c >= -TOL_S) && (err_c <= TOL_S);
    end
`endif

    // Next-state, counter and watchdog logic; a sample always beats expiry.
    always_comb begin
        nstate = cstate;
        good_n = good_cnt;
        bad_n  = bad_cnt;
        loss_n = 1'b0;
        wd_n   = (wd_cnt == TIMEOUT_C) ? wd_cnt : wd_cnt + 1'b1;
        if (meas_valid) begin
            wd_n = '0;
            case (cstate)
                IDLE, ACQUIRE: begin
                    good_n = in_win_c ? sat_inc((cstate == IDLE) ? '0 : good_cnt) : '0;
                    bad_n  = '0;
                    nstate = (good_n == LOCK_C) ? LOCKED : ACQUIRE;
                end
                LOCKED: begin
                    bad_n = in_win_c ? '0 : bad_cnt + 1'b1;
                    if (bad_n == UNLOCK_C) begin
                        nstate = ACQUIRE;
                        good_n = '0;
                        bad_n  = '0;
                    end
                end
                default: nstate = IDLE;
            endcase
        end else if ((cstate != IDLE) && (wd_cnt == TIMEOUT_C - 1'b1)) begin
            nstate = IDLE;
            good_n = '0;
            bad_n  = '0;
            loss_n = 1'b1;
        end
    end

    // Control state register: FSM, hysteresis counters, watchdog, loss pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cstate   <= IDLE;
            good_cnt <= '0;
            bad_cnt  <= '0;
            wd_cnt   <= '0;
            loss     <= 1'b0;
        end else begin
            cstate   <= nstate;
            good_cnt <= good_n;
            bad_cnt  <= bad_n;
            wd_cnt   <= wd_n;
            loss     <= loss_n;
        end
    end

    // Measurement results; the first sample out of IDLE seeds the average.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_err <= '0;
            in_window  <= 1'b0;
            avg_period <= '0;
        end else if (meas_valid) begin
            period_err <= err_c;
            in_window  <= in_win_c;
            avg_period <= (cstate == IDLE) ? period : avg_step(avg_period, period);
        end
    end

    assign state  = cstate;
    assign locked = (cstate == LOCKED);

endmodule

// File: tb/tb_sync_lock_monitor.sv
// Self-checking bench for sync_lock_monitor: directed table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_sync_lock_monitor;

    localparam int WIDTH = 32;
    localparam int NOM = 60;
    localparam int TOL = 4;
    localparam int LOCKN = 4;
    localparam int UNLOCKN = 3;
    localparam int TMO = 200;
    localparam int DNOM = 20;
    localparam int DTOL = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [WIDTH-1:0]      period = '0;
    logic [WIDTH-1:0]      duty = '0;
    logic                  meas_valid = 1'b0;
    logic [1:0]            state;
    logic                  locked;
    logic                  in_window;
    logic signed [WIDTH:0] period_err;
    logic [WIDTH-1:0]      avg_period;
    logic                  loss;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sync_lock_monitor #(
        .WIDTH(WIDTH), .NOM_PERIOD(NOM), .TOL(TOL), .LOCK_COUNT(LOCKN),
        .UNLOCK_COUNT(UNLOCKN), .TIMEOUT(TMO), .AVG_SHIFT(2),
        .DUTY_NOM(DNOM), .DUTY_TOL(DTOL)
    ) dut (
        .clock(clock), .reset(reset), .period(period), .duty(duty),
        .meas_valid(meas_valid), .state(state), .locked(locked),
        .in_window(in_window), .period_err(period_err),
        .avg_period(avg_period), .loss(loss)
    );

    // ---------------- behavioural reference model ----------------
    int     m_state;      // 0 idle, 1 acquiring, 2 locked
    int     m_good_run;   // consecutive in-window samples while acquiring
    int     m_bad_run;    // consecutive out-of-window samples while locked
    longint m_avg, m_err, m_cyc, m_last;
    bit     m_inw, m_loss;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        m_state = 0; m_good_run = 0; m_bad_run = 0;
        m_avg = 0; m_err = 0; m_inw = 0; m_loss = 0; m_last = m_cyc;
    endtask

    task automatic model_step(input bit v, input int p, input int d);
        longint de;
        m_cyc++;
        m_loss = 0;
        if (v) begin
            m_err = longint'(p) - NOM;
            m_inw = (m_err >= -TOL) && (m_err <= TOL);
`ifdef SYNC_LOCK_DUTY_CHECK_EN
            de = longint'(d) - DNOM;
            m_inw = m_inw && (de >= -DTOL) && (de <= DTOL);
`else
            de = longint'(d);
`endif
            if (m_state == 0) m_avg = p;
            else m_avg = (m_avg + floor_div(longint'(p) - m_avg, 4)) % (64'd1 << WIDTH);
            if (m_state == 0) begin
                m_state = 1;
                m_good_run = 0;
            end
            if (m_state == 1) begin
                m_good_run = m_inw ? ((m_good_run + 1 > LOCKN) ? LOCKN : m_good_run + 1) : 0;
                if (m_good_run == LOCKN) begin
                    m_state = 2;
                    m_bad_run = 0;
                end
            end else begin
                m_bad_run = m_inw ? 0 : m_bad_run + 1;
                if (m_bad_run == UNLOCKN) begin
                    m_state = 1;
                    m_good_run = 0;
                    m_bad_run = 0;
                end
            end
            m_last = m_cyc;
        end else if ((m_state != 0) && (m_cyc - m_last == TMO)) begin
            m_state = 0;
            m_loss = 1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int st, input bit lk, input bit iw,
                             input longint er, input longint av, input bit ls);
        chk({tag, ".state"}, 64'(state), 64'(st));
        chk({tag, ".locked"}, 64'(locked), 64'(lk));
        chk({tag, ".in_window"}, 64'(in_window), 64'(iw));
        chk({tag, ".period_err"}, 64'($signed(period_err)), er);
        chk({tag, ".avg_period"}, 64'(avg_period), av);
        chk({tag, ".loss"}, 64'(loss), 64'(ls));
    endtask

    task automatic check_model(input string tag);
        check_out(tag, m_state, m_state == 2, m_inw, m_err, m_avg, m_loss);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model.
    task automatic tick(input bit v, input int p, input int d);
        meas_valid = v;
        period = 32'(p);
        duty = 32'(d);
        @(posedge clock);
        if (reset) model_reset();
        else model_step(v, p, d);
        #1;
        meas_valid = 1'b0;
    endtask

    task automatic sample_then_gap(input int p, input int d, input int gap);
        tick(1'b1, p, d);
        repeat (gap) tick(1'b0, 0, DNOM);
    endtask

    typedef struct {
        int     p;
        int     st;
        bit     lk;
        bit     iw;
        longint er;
        longint av;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int pulses;
        int first_loss;
        int exp_iw;
        int gap;
        int r;
        int p;
        int d;

        tbl[0] = '{60, 1, 0, 1,   0, 60};
        tbl[1] = '{64, 1, 0, 1,   4, 61};
        tbl[2] = '{56, 1, 0, 1,  -4, 59};
        tbl[3] = '{60, 2, 1, 1,   0, 59};
        tbl[4] = '{65, 2, 1, 0,   5, 60};
        tbl[5] = '{ 0, 2, 1, 0, -60, 45};
        tbl[6] = '{60, 2, 1, 1,   0, 48};
        tbl[7] = '{70, 2, 1, 0,  10, 53};
        tbl[8] = '{50, 2, 1, 0, -10, 52};
        tbl[9] = '{80, 1, 0, 0,  20, 59};

        m_cyc = 0;
        model_reset();

        // Reset state
        repeat (3) tick(1'b0, 0, DNOM);
        check_out("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Directed table: acquire, window edges, hysteresis, unlock
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, tbl[i].p, DNOM);
            check_out($sformatf("table%0d", i), tbl[i].st, tbl[i].lk, tbl[i].iw,
                      tbl[i].er, tbl[i].av, 0);
            repeat (29) tick(1'b0, 0, DNOM);
        end

        // Asynchronous reset mid-run
        tick(1'b1, 60, DNOM);
        reset = 1'b1;
        #2;
        check_out("async_reset", 0, 0, 0, 0, 0, 0);
        repeat (2) tick(1'b0, 0, DNOM);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 250; i++) begin
            tick(1'b0, 0, DNOM);
            if (loss === 1'b1) pulses++;
        end
        chk("no_loss_after_reset", 64'(pulses), 64'd0);
        tick(1'b1, 65, DNOM);
        check_out("first_after_reset", 1, 0, 0, 5, 65, 0);

        // Lock, then lose the signal
        for (int k = 0; k < 4; k++) sample_then_gap(60, DNOM, (k == 3) ? 0 : 29);
        chk("relock.state", 64'(state), 64'd2);
        chk("relock.locked", 64'(locked), 64'd1);
        pulses = 0;
        first_loss = -1;
        for (int i = 1; i <= 300; i++) begin
            tick(1'b0, 0, DNOM);
            if (loss === 1'b1) begin
                pulses++;
                if (first_loss < 0) first_loss = i;
            end
            if (i == 200) chk("loss.state", 64'(state), 64'd0);
        end
        chk("loss.cycle", 64'(first_loss), 64'd200);
        chk("loss.pulses", 64'(pulses), 64'd1);

        // Lock from IDLE, then a strobe exactly on the expiry cycle
        tick(1'b1, 60, DNOM);
        chk("acq_first.state", 64'(state), 64'd1);
        repeat (29) tick(1'b0, 0, DNOM);
        for (int k = 1; k < 4; k++) sample_then_gap(60, DNOM, (k == 3) ? 0 : 29);
        check_out("lock4", 2, 1, 1, 0, 60, 0);
        pulses = 0;
        repeat (199) begin
            tick(1'b0, 0, DNOM);
            if (loss === 1'b1) pulses++;
        end
        tick(1'b1, 60, DNOM);
        chk("expiry_strobe.pulses", 64'(pulses), 64'd0);
        chk("expiry_strobe.loss", 64'(loss), 64'd0);
        chk("expiry_strobe.state", 64'(state), 64'd2);
        tick(1'b0, 0, DNOM);
        chk("expiry_strobe.after", 64'(loss), 64'd0);

        // Duty window
`ifdef SYNC_LOCK_DUTY_CHECK_EN
        exp_iw = 0;
`else
        exp_iw = 1;
`endif
        tick(1'b1, 60, 23);
        chk("duty23.in_window", 64'(in_window), 64'(exp_iw));
        tick(1'b1, 60, 22);
        chk("duty22.in_window", 64'(in_window), 64'd1);

        // Randomized traffic against the reference model
        reset = 1'b1;
        tick(1'b0, 0, DNOM);
        reset = 1'b0;
        for (int burst = 0; burst < 400 && m_cyc < 20000; burst++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) gap = int'($urandom_range(199, 201));
            else if (r == 1) gap = int'($urandom_range(150, 260));
            else gap = int'($urandom_range(0, 40));
            p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(54, 66)) : int'($urandom_range(0, 150));
            d = int'($urandom_range(16, 24));
            tick(1'b1, p, d);
            check_model("rand");
            for (int g = 0; g < gap; g++) begin
                tick(1'b0, 0, d);
                check_model("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
